tdm_demux_1x4: RTL and testbench
================================

# tdm_demux_1x4

Time-division demultiplexer, the receive-side counterpart of the 4:1 channel mux. It takes a single serial slot stream, steers each accepted slot to channel 0..3 in rotation and assembles one frame of four channel words. Each completed frame is presented on a registered valid/ready output. It sits between the shared serial link and the per-channel consumers.

## Interface
- DW, 1, width of one channel word / one slot.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  slot present on in_data.
- in_ready  out  1  block accepts slot this cycle.
- in_data  in  DW  slot payload.
- in_sof  in  1  start of frame, qualified by in_valid; marks the slot as channel 0.
- out_valid  out  1  assembled frame available.
- out_ready  in  1  consumer takes frame.
- out_data  out  4*DW  channel k at bits [k*DW +: DW].
- out_err  out  1  frame parity mismatch; valid with out_valid.
- slot_idx  out  3  current slot counter, for debug.

## Operation
- Accept when in_valid && in_ready. Accepted slot is written to assembly register slot_idx; slot_idx increments.
- Last slot: index 3, or index 4 when parity is enabled. Accepting the last slot copies the assembly register to out_data, sets out_valid and wraps slot_idx to 0.
- in_sof accepted: the slot is written as channel 0 regardless of slot_idx, and slot_idx becomes 1. Any partial frame is discarded with no output. in_sof on slot 0 is normal.
- Output register: out_valid clears on out_valid && out_ready unless a new frame loads in the same cycle, in which case it stays 1 with new data.
- Backpressure: in_ready = 0 only when slot_idx is the last slot and out_valid && !out_ready. At all other times in_ready = 1, so assembly of the next frame proceeds while the output is held.
- Frame arithmetic: no wrap of data. Channel words are stored verbatim.
- Reset values:
  - out_valid = 0, out_data = 0, out_err = 0, slot_idx = 0.
  - Assembly register = 0.
  - in_ready = 1.
- Reset mid-frame drops the partial frame and any unconsumed output.

## Timing
- Latency: out_valid rises on the clock edge that accepts the last slot, so it is visible the following cycle.
- Throughput: one slot per clock and one frame per 4 (or 5) clocks with no stalls when out_ready is held high.
- Simultaneous last-slot accept and output drain in the same cycle is legal and loses no frame.
- in_ready is combinational from out_valid, out_ready and slot_idx. There is no path from in_valid to in_ready.
- out_data and out_err are stable while out_valid && !out_ready.

## Configuration
- TDM_DEMUX_PARITY_EN defined:
  - The frame is 5 slots. Slot 4 carries even parity, computed as the bitwise XOR of channels 0..3, DW bits wide.
  - out_err = 1 when the received slot 4 does not equal that XOR.
  - Slot 4 is not part of out_data.
- Not defined:
  - The frame is 4 slots.
  - out_err is tied 0.
  - slot_idx never exceeds 3.

## Structure
- The shared package tdm_pkg holds:
  - N_CH = 4.
  - The slot-index width.
  - The function computing last-slot index from the parity configuration.
  - The parity function: XOR-reduce of N_CH words.
- One natural sub-module is tdm_slot_counter. It covers slot_idx, the sof resync and the wrap/last-slot decode, and is reused by the matching mux-side framer.
- The data path and output register stay in the top module.

## Test plan
- Reset, then 4 slots 1,0,1,1 with sof on the first, DW=1, out_ready=1 -> the cycle after the 4th slot, out_valid=1 and out_data=4'b1101; slot_idx=0.
- Hold out_ready=0, then send two frames 1,0,0,0 and 0,1,1,1 -> first frame held as out_data=4'b0001. in_ready drops at the second frame's last slot. On out_ready=1, 4'b0001 is taken, then 4'b1110 follows with no slot lost.
- Frame 1,1 then sof with 0,0,1,0 -> no output for the partial frame; out_data=4'b0100.
- Assert rst_n low after 2 slots, release, send 0,1,0,1 -> single out_data=4'b1010; all outputs zero while in reset.
- With TDM_DEMUX_PARITY_EN, send 1,0,1,1,parity 1 -> out_err=0, out_data=4'b1101. Same data with parity 0 -> out_err=1.
- Back-to-back frames with out_ready=1 -> out_valid pulses every 4th cycle (5th with parity) and in_ready stays 1 throughout.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and helpers for the TDM mux/demux family
// Holds channel count, slot-index width, last-slot decode and the slot parity function.
package tdm_pkg;
  localparam int N_CH = 4;
  localparam int SW = 3;
  localparam int CW = $clog2(N_CH);
  localparam int PW = 32;
  function automatic logic [SW-1:0] last_slot(input bit par_en);
    return par_en ? SW'(N_CH) : SW'(N_CH - 1);
  endfunction
  function automatic logic [PW-1:0] parity(input logic [N_CH-1:0][PW-1:0] w);
    parity = '0;
    for (int k = 0; k < N_CH; k++) parity ^= w[k];
  endfunction
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: slot index with sof resync and last-slot wrap
// Ports: clk, rst_n (async, active low), acc (slot accepted), sof (accepted slot is channel 0),
//        slot_idx (current slot), wr_idx (slot the current input lands in),
//        last (slot_idx is the last slot), done (frame completes this cycle).
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter logic [SW-1:0] LAST = SW'(N_CH - 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          acc,
  input  logic          sof,
  output logic [SW-1:0] slot_idx,
  output logic [SW-1:0] wr_idx,
  output logic          last,
  output logic          done
);
  assign last = slot_idx == LAST;
  assign wr_idx = sof ? '0 : slot_idx;
  // an sof slot is always channel 0, so it can never close a frame
  assign done = acc && !sof && last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) slot_idx <= '0;
    else if (acc) slot_idx <= sof ? SW'(1) : last ? '0 : slot_idx + SW'(1);
endmodule

// File: rtl/tdm_demux_1x4.sv
// tdm_demux_1x4: serial slot stream to 4-channel frame demultiplexer
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_data/in_sof slot input;
//        out_valid/out_ready/out_data/out_err registered frame output; slot_idx debug.
// Macro TDM_DEMUX_PARITY_EN: 5-slot frames with slot 4 carrying XOR parity of channels 0..3.
module tdm_demux_1x4
  import tdm_pkg::*;
#(
  parameter int DW = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic            in_sof,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*DW-1:0] out_data,
  output logic            out_err,
  output logic [SW-1:0]   slot_idx
);
`ifdef TDM_DEMUX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic [SW-1:0] wr_idx;
  logic last, done, acc;
  logic [N_CH-1:0][DW-1:0] asm_q, frm;
  assign in_ready = !(last && out_valid && !out_ready);
  assign acc = in_valid && in_ready;
  tdm_slot_counter #(.LAST(last_slot(PAR))) u_cnt (
    .clk(clk), .rst_n(rst_n), .acc(acc), .sof(in_sof),
    .slot_idx(slot_idx), .wr_idx(wr_idx), .last(last), .done(done)
  );
  // frame as it will look after this cycle's slot; the parity slot is not stored
  always_comb begin
    frm = asm_q;
    if (acc && wr_idx < SW'(N_CH)) frm[wr_idx[CW-1:0]] = in_data;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      asm_q <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
    end else begin
      if (acc) asm_q <= frm;
      if (done) out_data <= frm;
      out_valid <= done || (out_valid && !out_ready);
    end
`ifdef TDM_DEMUX_PARITY_EN
  logic [N_CH-1:0][PW-1:0] pw;
  always_comb for (int k = 0; k < N_CH; k++) pw[k] = PW'(asm_q[k]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out_err <= 1'b0;
    else if (done) out_err <= parity(pw) != PW'(in_data);
`else
  assign out_err = 1'b0;
`endif
endmodule

// File: tb/tb_tdm_demux_1x4.sv
// tb_tdm_demux_1x4: randomized scoreboard bench for tdm_demux_1x4
module tb_tdm_demux_1x4;
  localparam int DW = 1;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FR = 5;
`else
  localparam int FR = 4;
`endif
  logic clk = 0, rst_n = 0, in_valid = 0, in_sof = 0, out_ready = 0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid, out_err;
  logic [4*DW-1:0] out_data;
  logic [2:0] slot_idx;
  typedef struct packed {logic [4*DW-1:0] d; logic e;} exp_t;
  exp_t sb[$];
  logic [DW-1:0] fr[$];
  bit ov;
  int n_cmp, n_bad, stalls;

  tdm_demux_1x4 #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .slot_idx(slot_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // one clock: drive, check the model's view at negedge, advance the model by the frame rules
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic s, input logic r, output bit acc);
    exp_t e;
    logic [DW-1:0] x;
    bit dn;
    in_valid = v; in_data = d; in_sof = s; out_ready = r;
    @(negedge clk);
    chk("in_ready", in_ready, !(fr.size() == FR - 1 && ov && !r));
    chk("slot_idx", slot_idx, fr.size());
    chk("out_valid", out_valid, ov);
    acc = v && in_ready;
    if (v && !in_ready) stalls++;
    dn = 0;
    if (acc) begin
      if (s) fr.delete();
      fr.push_back(d);
      if (fr.size() == FR) begin
        x = '0;
        for (int k = 0; k < 4; k++) begin
          e.d[k*DW +: DW] = fr[k];
          x ^= fr[k];
        end
        e.e = (FR == 5) && (x != fr[FR-1]);
        sb.push_back(e);
        fr.delete();
        dn = 1;
      end
    end
    ov = dn || (ov && !r);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic s, input logic r);
    bit a;
    int t = 0;
    do begin
      cyc(1'b1, d, s, (t >= 2) ? 1'b1 : r, a);
      t++;
    end while (!a && t < 10);
    if (!a) fail("send_timeout");
  endtask

  task automatic send_frame(input logic [3:0] w, input logic r, input logic bad);
    for (int k = 0; k < 4; k++) send(w[k], k == 0, r);
    if (FR == 5) send(^w ^ bad, 1'b0, r);
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) cyc(1'b0, '0, 1'b0, 1'b1, a);
  endtask

  task automatic do_reset();
    rst_n = 0; in_valid = 0; in_sof = 0; out_ready = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_slot_idx", slot_idx, 0);
    chk("rst_in_ready", in_ready, 1);
    fr.delete(); sb.delete(); ov = 0;
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) fail("unexpected_frame");
        else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_err", out_err, e.e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    @(posedge clk);
    #1;
    do_reset();
    send_frame(4'b1101, 1'b1, 1'b0);
    idle(1);
    chk("basic_data", out_data, 4'b1101);
    send_frame(4'b0001, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b0, a);
    chk("bp_hold", out_data, 4'b0001);
    stalls = 0;
    send_frame(4'b1110, 1'b0, 1'b0);
    chk("bp_stalls", stalls, 2);
    idle(2);
    chk("bp_second", out_data, 4'b1110);
    send(1'b1, 1'b1, 1'b1);
    send(1'b1, 1'b0, 1'b1);
    send_frame(4'b0100, 1'b1, 1'b0);
    idle(1);
    chk("sof_resync", out_data, 4'b0100);
    send(1'b1, 1'b1, 1'b1);
    send(1'b0, 1'b0, 1'b1);
    do_reset();
    send_frame(4'b1010, 1'b1, 1'b0);
    idle(1);
    chk("after_reset", out_data, 4'b1010);
`ifdef TDM_DEMUX_PARITY_EN
    send_frame(4'b1101, 1'b1, 1'b0);
    idle(1);
    chk("par_ok", out_err, 0);
    send_frame(4'b1101, 1'b1, 1'b1);
    idle(1);
    chk("par_bad", out_err, 1);
`endif
    stalls = 0;
    for (int i = 0; i < 10; i++) send_frame(4'($urandom), 1'b1, 1'($urandom_range(0, 1)));
    chk("b2b_stalls", stalls, 0);
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 9) < 8, DW'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7, a);
    idle(5);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
